// File: rtl/ara_pe_req_broadcast_pkg.sv
// ara_pe_req_broadcast_pkg: request type, PE index offsets and the hazard scrub helper.
package ara_pe_req_broadcast_pkg;
  localparam int NrVInsn = 8;
  localparam int OffsetLoad = 0;
  localparam int OffsetStore = 1;
  localparam int OffsetSlide = 2;
  localparam int OffsetMask = 3;
  localparam int NrExtraPEs = 4;
  typedef logic [$clog2(NrVInsn)-1:0] vid_t;
  typedef struct packed {
    vid_t id;
    logic [7:0] op;
    logic [NrVInsn-1:0] hazard_vs1;
    logic [NrVInsn-1:0] hazard_vs2;
    logic [NrVInsn-1:0] hazard_vd;
    logic [NrVInsn-1:0] hazard_vm;
    logic [NrVInsn-1:0] vinsn_running;
  } pe_req_t;
  // Hazards may only shrink to instructions still running.
  function automatic pe_req_t scrub(input pe_req_t r, input logic [NrVInsn-1:0] running);
    scrub = r;
    scrub.hazard_vs1 = r.hazard_vs1 & running;
    scrub.hazard_vs2 = r.hazard_vs2 & running;
    scrub.hazard_vd = r.hazard_vd & running;
    scrub.hazard_vm = r.hazard_vm & running;
    scrub.vinsn_running = running;
  endfunction
endpackage

// File: rtl/ara_pe_req_broadcast_if.sv
// ara_pe_req_broadcast_if: sequencer-side and PE-side request signals of the broadcast queue.
interface ara_pe_req_broadcast_if import ara_pe_req_broadcast_pkg::*; #(parameter int NrPEs = 8);
  pe_req_t req;
  logic [NrPEs-1:0] req_target;
  logic req_valid;
  logic req_ready;
  logic [NrVInsn-1:0] vinsn_running;
  pe_req_t pe_req;
  logic [NrPEs-1:0] pe_req_valid;
  logic [NrPEs-1:0] pe_req_ready;
  logic idle;
  modport master (
    output req, req_target, req_valid, vinsn_running, pe_req_ready,
    input req_ready, pe_req, pe_req_valid, idle
  );
  modport slave (
    input req, req_target, req_valid, vinsn_running, pe_req_ready,
    output req_ready, pe_req, pe_req_valid, idle
  );
endinterface

// File: rtl/ara_pe_req_broadcast_accept.sv
// ara_pe_accept_tracker: records which PEs took the head request and flags when all targets have.
module ara_pe_accept_tracker #(
  parameter int NrPEs = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic head_valid,
  input  logic [NrPEs-1:0] target,
  input  logic [NrPEs-1:0] ready,
  output logic [NrPEs-1:0] pe_valid,
  output logic done
);
  logic [NrPEs-1:0] sent;
  logic [NrPEs-1:0] hs;
  assign pe_valid = {NrPEs{head_valid}} & target & ~sent;
  assign hs = pe_valid & ready;
  assign done = head_valid && (((sent | hs) & target) == target);
  always_ff @(posedge clk) begin
    if (rst || done) sent <= '0;
    else sent <= sent | hs;
  end
endmodule

// File: rtl/ara_pe_req_broadcast.sv
// ara_pe_req_broadcast: in-order request queue broadcasting its head to a per-request subset of PEs.
module ara_pe_req_broadcast import ara_pe_req_broadcast_pkg::*; #(
  parameter int NrLanes = 4,
  parameter int Depth = 2
) (
  input logic clk,
  input logic rst,
  ara_pe_req_broadcast_if.slave bus
);
  localparam int NrPEs = NrLanes + NrExtraPEs;
  localparam int PtrW = Depth > 1 ? $clog2(Depth) : 1;
  localparam int CntW = $clog2(Depth + 1);
  typedef logic [NrPEs-1:0] pe_target_t;
  pe_req_t req_q [Depth];
  pe_target_t tgt_q [Depth];
  logic [PtrW-1:0] rd, wr;
  logic [CntW-1:0] count;
  logic empty, push, pop;
  pe_target_t pe_valid;
  function automatic logic [PtrW-1:0] nxt(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction
  assign empty = count == '0;
  assign bus.req_ready = !rst && count < CntW'(Depth);
  assign push = bus.req_valid && bus.req_ready;
  assign bus.idle = empty;
  assign bus.pe_req = empty ? '0 : req_q[rd];
  assign bus.pe_req_valid = pe_valid;
  ara_pe_accept_tracker #(.NrPEs(NrPEs)) u_accept (
    .clk(clk),
    .rst(rst),
    .head_valid(!empty),
    .target(tgt_q[rd]),
    .ready(bus.pe_req_ready),
    .pe_valid(pe_valid),
    .done(pop)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      rd <= '0;
      wr <= '0;
    end else begin
      if (push) wr <= nxt(wr);
      if (pop) rd <= nxt(rd);
      count <= count + CntW'(push) - CntW'(pop);
    end
  end
  // Every slot is scrubbed each cycle; a push then overwrites its own slot.
  always_ff @(posedge clk) begin
    for (int i = 0; i < Depth; i++) req_q[i] <= scrub(req_q[i], bus.vinsn_running);
    if (push) begin
      req_q[wr] <= scrub(bus.req, bus.vinsn_running);
      tgt_q[wr] <= bus.req_target;
    end
  end
endmodule

// File: doc/ara_pe_req_broadcast.md
Name: ara_pe_req_broadcast

Overview:
Sits directly downstream of the sequencer and upstream of the processing elements (lanes, load, store, slide and mask units). It buffers issued PE requests in a small in-order queue and broadcasts the head request to a per-request subset of PEs. Each PE accepts the head independently, so a slow PE no longer stalls the sequencer's single all-PE handshake. While requests wait in the queue, their hazard bits are scrubbed against the currently running instructions.

Parameters:
NrLanes, 4, number of vector lanes
NrPEs, NrLanes+4, lanes plus load, store, slide and mask units (derived; do not override)
Depth, 2, queue entries; must be >= 1

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, synchronous, active-high
req_i  in  pe_req_t  request from sequencer
req_target_i  in  NrPEs  PEs that must accept req_i; bit p means PE p
req_valid_i  in  1  request valid
req_ready_o  out  1  queue can accept a request
vinsn_running_i  in  NrVInsn  instructions currently running in Ara
pe_req_o  out  pe_req_t  head request, shared by all PEs
pe_req_valid_o  out  NrPEs  per-PE valid
pe_req_ready_i  in  NrPEs  per-PE ready
idle_o  out  1  queue empty

Behaviour:
Clock and reset:
- One clock, clk_i. rst_i is synchronous and active-high.
- Reset clears count, read/write pointers, and the sent masks of all entries.
- Reset values: pe_req_valid_o='0, req_ready_o=0 while rst_i is high, idle_o=1, pe_req_o='0.
- A reset during a partially accepted broadcast drops the entry. Any PE that already accepted it keeps its copy.

Entry and handshakes:
- Each entry holds {req, target, sent}; sent has NrPEs bits.
- Push occurs when req_valid_i && req_ready_o.
- req_ready_o = (count < Depth). It does not depend on pops in the same cycle, so there is no ready-to-ready combinational path.
- Latency: a request pushed at cycle t appears on pe_req_o at t+1 at the earliest, when the queue was empty.
- pe_req_valid_o[p] = !empty && head.target[p] && !head.sent[p].
- PE p handshakes when pe_req_valid_o[p] && pe_req_ready_i[p]. It then sets head.sent[p]; valid[p] drops the next cycle.
- head_done = ((head.sent | handshakes) & head.target) == head.target. On head_done the entry pops, the read pointer advances and the sent mask clears.
- If head.target == '0, the entry pops the first cycle it is head, with no valids asserted.
- Push and pop in the same cycle leave count unchanged. Push while full cannot occur because ready is low.
- Pointers are clog2(Depth) bits wide and wrap at Depth-1 back to 0. For Depth=1 there are no pointers. count is clog2(Depth+1) bits.

Stability:
- Once any pe_req_valid_o bit is asserted for the head, pe_req_o holds until pop.
- The only exceptions are hazard_vs1/vs2/vd/vm and vinsn_running, which may only lose bits.

Hazard scrub:
- Each cycle, every stored entry and the incoming req_i on push are updated as: hazard_x &= vinsn_running_i for x in {vs1, vs2, vd, vm}, and vinsn_running = vinsn_running_i.
- pe_req_o shows the scrubbed, registered value of the head.

Other:
- idle_o = (count == 0).
- Requests leave in strict FIFO order; there is no reordering between entries.

Decomposition:
- ara_pkg: reuses pe_req_t, vid_t and NrVInsn. Adds the PE index constants OffsetLoad/Store/Slide/Mask if not already present. Adds typedef pe_target_t as a parameterised-width mask, defined as logic [NrPEs-1:0] at the use site.
- Storage, pointers and sent tracking are implemented inline. A generic FIFO does not fit, because the per-entry hazard scrub needs access to every entry each cycle.
- The one natural sub-module is ara_pe_accept_tracker: the per-head sent mask and head_done logic, parameterised by NrPEs.

Test Plan:
- Single broadcast: push req id=3, target=8'hFF, all ready. Expect pe_req_valid_o=8'hFF one cycle after push. The entry pops the same cycle and idle_o=1 the next cycle.
- Staggered accept: target=8'h0F. Ready PE0 at cycle 1, PE1–PE3 at cycle 3. Expect valid 8'h0F, then 8'h0E, held until cycle 3. Pop at cycle 3, and pe_req_o unchanged in cycles 1–3.
- Full/backpressure: Depth=2, all PEs not ready. Push 2 requests and expect req_ready_o=0. Raise all readies and expect ready=1 one cycle after the first pop, then both entries delivered in order.
- Hazard scrub: push hazard_vs1=8'b0000_0110 with vinsn_running_i=8'b0000_0110 while the head is blocked. Drop vinsn_running_i bit 1. Expect the queued entry's hazard_vs1=8'b0000_0100 when it reaches head.
- Zero target: push target=0 then a request with target=1. Expect no valid for the first and PE0 valid for the second.
- Mid-broadcast reset: target=8'h03, PE0 accepted. Assert rst_i for 1 cycle. Expect valid='0, idle_o=1, req_ready_o=0 during reset and 1 after.
